// File: rtl/io_seg_driver.sv
// io_seg_driver: converts a binary value to NDIGITS active-low 7-segment glyphs (double-dabble).
// Latency: seg/ovf update WIDTH+1 edges after the accepting edge (1 edge in hex mode).
// Backpressure: busy=1 while converting; wr_en is dropped, not queued, while busy. Optional macro: IO_SEG_HEX_EN.
module io_seg_driver #(
  parameter int WIDTH   = 32,
  parameter int NDIGITS = 2,
  parameter int LZB     = 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
`ifdef IO_SEG_HEX_EN
  input  logic                   hex_mode,
`endif
  output logic                   busy,
  output logic [7*NDIGITS-1:0]   seg,
  output logic                   ovf
);

  localparam int BW = 4 * NDIGITS;
  localparam int SW = 7 * NDIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int XW = (WIDTH > BW) ? WIDTH : BW;
  localparam logic [6:0]    BLANK   = 7'b1111111;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  // Active-low glyph for one digit; A..F only reachable in hex mode.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0: g = 7'b1000000;
      4'd1: g = 7'b1111001;
      4'd2: g = 7'b0100100;
      4'd3: g = 7'b0110000;
      4'd4: g = 7'b0011001;
      4'd5: g = 7'b0010010;
      4'd6: g = 7'b0000010;
      4'd7: g = 7'b1111000;
      4'd8: g = 7'b0000000;
      4'd9: g = 7'b0010000;
`ifdef IO_SEG_HEX_EN
      4'd10: g = 7'b0001000;
      4'd11: g = 7'b0000011;
      4'd12: g = 7'b1000110;
      4'd13: g = 7'b0100001;
      4'd14: g = 7'b0000110;
      4'd15: g = 7'b0001110;
`endif
      default: g = BLANK;
    endcase
    return g;
  endfunction

  // Display of the value zero: only digit 0 lit when blanking leading zeros.
  function automatic logic [SW-1:0] seg_init();
    logic [SW-1:0] r;
    for (int k = 0; k < NDIGITS; k++) begin
      r[7*k +: 7] = ((LZB != 0) && (k != 0)) ? BLANK : 7'b1000000;
    end
    return r;
  endfunction

  localparam logic [SW-1:0] SEG_RST = seg_init();

  state_t          state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            oflag_q, oflag_d;
  logic [SW-1:0]   seg_q, seg_d;
  logic            ovf_q, ovf_d;

  logic [BW-1:0]   adj;
  logic [SW-1:0]   disp;
  logic            lead;
  logic            hex_sel;
  logic [XW-1:0]   ext;

`ifdef IO_SEG_HEX_EN
  assign hex_sel = hex_mode;
`else
  assign hex_sel = 1'b0;
`endif
  assign ext = XW'(wr_data);

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: hex writes bypass the conversion phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_en) state_d = hex_sel ? LOAD : CONV;
      CONV:    if (cnt_q == CNT_ONE) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Add-3 correction of every BCD digit ahead of the shift.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < NDIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
  end

  // Glyph image of the accumulator, with overflow and leading-zero blanking.
  always_comb begin
    disp = '0;
    lead = 1'b1;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) lead = 1'b0;
      if (oflag_q)                              disp[7*k +: 7] = BLANK;
      else if ((LZB != 0) && lead && (k != 0))  disp[7*k +: 7] = BLANK;
      else                                      disp[7*k +: 7] = glyph(bcd_q[4*k +: 4]);
    end
  end

  // Datapath next values: capture, shift-add-3 step, or display load.
  always_comb begin
    val_d   = val_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    oflag_d = oflag_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          if (hex_sel) begin
            val_d   = wr_data;
            bcd_d   = ext[BW-1:0];
            oflag_d = ((ext >> BW) != '0);
            cnt_d   = '0;
          end else begin
            val_d   = wr_data;
            bcd_d   = '0;
            oflag_d = 1'b0;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      CONV: begin
        val_d   = val_q << 1;
        bcd_d   = {adj[BW-2:0], val_q[WIDTH-1]};
        oflag_d = oflag_q | adj[BW-1];
        cnt_d   = cnt_q - CNT_ONE;
      end
      LOAD: begin
        seg_d = disp;
        ovf_d = oflag_q;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      val_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      oflag_q <= 1'b0;
      seg_q   <= SEG_RST;
      ovf_q   <= 1'b0;
    end else begin
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      oflag_q <= oflag_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign seg = seg_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_io_seg_driver.sv
// Bench for io_seg_driver at default parameters: directed cases plus random values
// compared against an arithmetic (divide/modulo) model of the display.
module tb_io_seg_driver;
  localparam int WIDTH = 32;
  localparam int ND    = 2;
  localparam int LZB   = 1;

  logic              clock   = 1'b0;
  logic              resetn  = 1'b0;
  logic              wr_en   = 1'b0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              busy;
  logic [7*ND-1:0]   seg;
  logic              ovf;
`ifdef IO_SEG_HEX_EN
  logic              hex_mode = 1'b0;
`endif

  int checks = 0;
  int passes = 0;

  logic [6:0] gly [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clock = ~clock;

  io_seg_driver #(.WIDTH(WIDTH), .NDIGITS(ND), .LZB(LZB)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
`ifdef IO_SEG_HEX_EN
    .hex_mode(hex_mode),
`endif
    .busy    (busy),
    .seg     (seg),
    .ovf     (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic model_ovf(input longint unsigned v, input int base);
    longint unsigned lim = 1;
    for (int i = 0; i < ND; i++) lim = lim * longint'(base);
    return v >= lim;
  endfunction

  // Digit k = (v / base^k) mod base; blank leading positions where v < base^k.
  function automatic logic [7*ND-1:0] model_seg(input longint unsigned v, input int base);
    longint unsigned pw = 1;
    logic [7*ND-1:0] r;
    int d;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      d = int'((v / pw) % longint'(base));
      if (model_ovf(v, base))              r[7*k +: 7] = 7'b1111111;
      else if (LZB != 0 && k > 0 && v < pw) r[7*k +: 7] = 7'b1111111;
      else                                 r[7*k +: 7] = gly[d];
      pw = pw * longint'(base);
    end
    return r;
  endfunction

  // Write one value, optionally inject a second write at busy cycle 'intr', then check the result.
  task automatic do_write(input string tag, input logic [31:0] v, input bit hex,
                          input int intr, input logic [31:0] idata);
    int n;
    bit stable;
    logic [7*ND-1:0] prev;
    int base;
    base = hex ? 16 : 10;
`ifdef IO_SEG_HEX_EN
    hex_mode = hex;
`endif
    wr_data = v;
    wr_en   = 1'b1;
    @(posedge clock); #1;
    wr_en   = 1'b0;
    prev    = seg;
    stable  = 1'b1;
    n       = 0;
    while (busy && n < 200) begin
      if (intr > 0 && n == intr - 1) begin
        wr_en   = 1'b1;
        wr_data = idata;
      end
      @(posedge clock); #1;
      wr_en = 1'b0;
      n++;
      if (busy && seg !== prev) stable = 1'b0;
    end
    check({tag, "_latency"}, n, hex ? 1 : WIDTH + 1);
    check({tag, "_stable"}, stable, 1'b1);
    check({tag, "_seg"}, seg, model_seg(v, base));
    check({tag, "_ovf"}, ovf, model_ovf(v, base));
`ifdef IO_SEG_HEX_EN
    hex_mode = 1'b0;
`endif
  endtask

  initial begin
    logic [31:0] rv;
    bit held;

    // Reset state, checked during and after reset.
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy_in", busy, 1'b0);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("rst_seg", seg, {7'b1111111, 7'b1000000});
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);

    // Directed decimal cases, back-to-back as soon as busy falls.
    do_write("w7", 32'd7, 1'b0, 0, 0);
    check("w7_const", seg, {7'b1111111, 7'b1111000});
    do_write("w99", 32'd99, 1'b0, 0, 0);
    check("w99_const", seg, {7'b0010000, 7'b0010000});
    do_write("w100", 32'd100, 1'b0, 0, 0);
    check("w100_const", seg, {7'b1111111, 7'b1111111});
    do_write("w42", 32'd42, 1'b0, 5, 32'd13);
    do_write("w0", 32'd0, 1'b0, 0, 0);
    do_write("w10", 32'd10, 1'b0, 0, 0);
    do_write("wmax", 32'hFFFF_FFFF, 1'b0, 0, 0);

    // Randomized values across digit-count and overflow ranges.
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = $urandom_range(0, 9);
        1:       rv = $urandom_range(0, 99);
        2:       rv = $urandom_range(100, 1000);
        default: rv = $urandom;
      endcase
      do_write("rand", rv, 1'b0, 0, 0);
    end

    // Reset in the middle of a conversion of 55.
    wr_data = 32'd55;
    wr_en   = 1'b1;
    @(posedge clock); #1;
    wr_en   = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    check("midrst_busy_before", busy, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    check("midrst_seg", seg, model_seg(0, 10));
    @(posedge clock); #1;
    resetn = 1'b1;
    held = 1'b1;
    repeat (40) begin
      @(posedge clock); #1;
      if (seg !== model_seg(0, 10) || busy !== 1'b0) held = 1'b0;
    end
    check("midrst_no55", held, 1'b1);

`ifdef IO_SEG_HEX_EN
    do_write("hex3c", 32'h3C, 1'b1, 0, 0);
    check("hex3c_const", seg, {7'b0110000, 7'b1000110});
    do_write("hex1ff", 32'h1FF, 1'b1, 0, 0);
    check("hex1ff_ovf", ovf, 1'b1);
    do_write("hex05", 32'h05, 1'b1, 0, 0);
    do_write("dec_after_hex", 32'd64, 1'b0, 0, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
